tdc_rx_merge: RTL and testbench

//  Merges N_CH first-word-fall-through (FWFT) TDC receiver FIFOs into one FWFT stream for bram_fifo_sbus.

---
 rtl/tdc_rx_merge.sv | 128 ++++++++++++
 tb/tb_tdc_rx_merge.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_rx_merge.sv
// Round-robin merge of N_CH FWFT TDC receiver FIFOs into one tagged FWFT stream.
// Optional per-grant bursting is enabled with the TDC_MERGE_BURST_EN macro.
module tdc_rx_merge #(
  parameter int N_CH       = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 2,
  parameter int MAX_BURST  = 8
) (
  input  logic                       BUS_CLK,
  input  logic                       BUS_RST_N,
  input  logic [N_CH-1:0]            CH_ENABLE,
  input  logic [N_CH-1:0]            IN_EMPTY,
  input  logic [N_CH*DATA_WIDTH-1:0] IN_DATA,
  output logic [N_CH-1:0]            IN_READ,
  input  logic                       OUT_READ,
  output logic                       OUT_EMPTY,
  output logic [DATA_WIDTH-1:0]      OUT_DATA,
  output logic                       OUT_RD_ERR,
  output logic [31:0]                WORD_CNT
);

  localparam int AW = $clog2(N_CH * DATA_WIDTH);

  if (N_CH < 2 || N_CH > 16 || (2 ** ID_WIDTH) < N_CH || DATA_WIDTH <= ID_WIDTH
      || MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_params
    $error("tdc_rx_merge: illegal parameter combination");
  end

  logic [DATA_WIDTH-1:0] mem_q [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            cnt_q, cnt_d;
  logic [ID_WIDTH-1:0]   last_q;
  logic [31:0]           word_cnt_q;
  logic                  rd_err_q;

  logic [N_CH-1:0]       req, rot;
  logic                  space, pop, push, found;
  logic [ID_WIDTH-1:0]   off, rr_idx, grant_idx;
  logic [31:0]           rr_sum;
  logic [AW-1:0]         base;
  logic [DATA_WIDTH-1:0] push_word;

`ifdef TDC_MERGE_BURST_EN
  logic [7:0] burst_q, burst_d;
  logic       req_last, hold;
`endif

  always_comb begin
    req   = CH_ENABLE & ~IN_EMPTY;
    space = (cnt_q < 2'd2) | ((cnt_q == 2'd2) & OUT_READ);
    pop   = OUT_READ & (cnt_q != 2'd0);

    // Rotate requests so bit 0 is last_grant+1; first set bit is the round-robin winner.
    rot   = N_CH'({req, req} >> (32'(last_q) + 32'd1));
    found = 1'b0;
    off   = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        off   = ID_WIDTH'(i);
      end
    end
    rr_sum = 32'(last_q) + 32'd1 + 32'(off);
    if (rr_sum >= 32'(N_CH)) begin
      rr_sum = rr_sum - 32'(N_CH);
    end
    rr_idx = ID_WIDTH'(rr_sum);

`ifdef TDC_MERGE_BURST_EN
    req_last  = |(req & (N_CH'(1) << last_q));
    hold      = (burst_q != 8'd0) && (burst_q < 8'(MAX_BURST)) && req_last;
    grant_idx = hold ? last_q : rr_idx;
    push      = space & (hold | found);
    burst_d   = burst_q;
    if (push) begin
      burst_d = hold ? burst_q + 8'd1 : 8'd1;
    end else if (!req_last) begin
      burst_d = 8'd0;
    end
`else
    grant_idx = rr_idx;
    push      = space & found;
`endif

    base      = AW'(32'(grant_idx) * 32'(DATA_WIDTH));
    push_word = {grant_idx, IN_DATA[base +: DATA_WIDTH-ID_WIDTH]};
    IN_READ   = push ? (N_CH'(1) << grant_idx) : '0;
    cnt_d     = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  // With cnt==2 and a simultaneous push/pop, wr_ptr equals rd_ptr: the slot being vacated is refilled.
  always_ff @(posedge BUS_CLK) begin
    if (!BUS_RST_N) begin
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
      last_q     <= ID_WIDTH'(N_CH - 1);
      word_cnt_q <= '0;
      rd_err_q   <= 1'b0;
`ifdef TDC_MERGE_BURST_EN
      burst_q    <= 8'd0;
`endif
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_word;
        wr_ptr_q        <= ~wr_ptr_q;
        last_q          <= grant_idx;
        word_cnt_q      <= word_cnt_q + 32'd1;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q    <= cnt_d;
      rd_err_q <= OUT_READ & (cnt_q == 2'd0);
`ifdef TDC_MERGE_BURST_EN
      burst_q  <= burst_d;
`endif
    end
  end

  assign OUT_EMPTY  = (cnt_q == 2'd0);
  assign OUT_DATA   = mem_q[rd_ptr_q];
  assign OUT_RD_ERR = rd_err_q;
  assign WORD_CNT   = word_cnt_q;

endmodule

// File: tb/tb_tdc_rx_merge.sv
// Directed bench for tdc_rx_merge: modelled source FIFOs, sink log and grant log.
module tb_tdc_rx_merge;
  localparam int N  = 4;
  localparam int DW = 32;

  logic          BUS_CLK = 1'b0;
  logic          BUS_RST_N;
  logic [N-1:0]  CH_ENABLE;
  logic [N-1:0]  IN_EMPTY;
  logic [N*DW-1:0] IN_DATA;
  logic [N-1:0]  IN_READ;
  logic          OUT_READ;
  logic          OUT_EMPTY;
  logic [DW-1:0] OUT_DATA;
  logic          OUT_RD_ERR;
  logic [31:0]   WORD_CNT;

  always #5 BUS_CLK = ~BUS_CLK;

  tdc_rx_merge #(
    .N_CH(N),
    .DATA_WIDTH(DW),
    .ID_WIDTH(2),
    .MAX_BURST(3)
  ) dut (
    .BUS_CLK(BUS_CLK),
    .BUS_RST_N(BUS_RST_N),
    .CH_ENABLE(CH_ENABLE),
    .IN_EMPTY(IN_EMPTY),
    .IN_DATA(IN_DATA),
    .IN_READ(IN_READ),
    .OUT_READ(OUT_READ),
    .OUT_EMPTY(OUT_EMPTY),
    .OUT_DATA(OUT_DATA),
    .OUT_RD_ERR(OUT_RD_ERR),
    .WORD_CNT(WORD_CNT)
  );

  int n_checks = 0;
  int n_errors = 0;

  int unsigned src_left [N];
  int unsigned src_idx  [N];
  logic [31:0] src_base [N];
  bit          src_fixed;
  logic [N-1:0] rd_seen, rd_or;
  int          grants[$];
  logic [31:0] outs[$];
  int          exp_g[10];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive_src();
    logic [N-1:0]    e;
    logic [N*DW-1:0] d;
    e = '0;
    d = '0;
    for (int k = 0; k < N; k++) begin
      if (src_left[k] == 0) e = e | (N'(1) << k);
      d = d | ((N*DW)'(src_fixed ? src_base[k] : src_base[k] + src_idx[k]) << (k*DW));
    end
    IN_EMPTY = e;
    IN_DATA  = d;
  endtask

  task automatic set_src(input int k, input int unsigned n, input logic [31:0] b);
    src_left[k] = n;
    src_idx[k]  = 0;
    src_base[k] = b;
  endtask

  // Called 1 time unit after a rising edge; samples at the falling edge, ends 1 unit after the next rise.
  task automatic step();
    #4;
    rd_seen = IN_READ;
    rd_or   = rd_or | IN_READ;
    for (int k = 0; k < N; k++)
      if (((IN_READ >> k) & N'(1)) != '0) grants.push_back(k);
    if (OUT_READ && !OUT_EMPTY) outs.push_back(OUT_DATA);
    @(posedge BUS_CLK);
    #1;
    for (int k = 0; k < N; k++) begin
      if ((((rd_seen >> k) & N'(1)) != '0) && src_left[k] > 0 && !src_fixed) begin
        src_left[k]--;
        src_idx[k]++;
      end
    end
    drive_src();
  endtask

  task automatic do_reset();
    BUS_RST_N = 1'b0;
    OUT_READ  = 1'b0;
    CH_ENABLE = '1;
    src_fixed = 1'b0;
    for (int k = 0; k < N; k++) set_src(k, 0, 32'h0);
    drive_src();
    step();
    step();
    BUS_RST_N = 1'b1;
    grants.delete();
    outs.delete();
    rd_or = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    BUS_RST_N = 1'b0;
    OUT_READ  = 1'b0;
    CH_ENABLE = '1;
    IN_EMPTY  = '1;
    IN_DATA   = '0;
    @(posedge BUS_CLK);
    #1;

    // Reset state and read-while-empty error
    do_reset();
    check("rst_empty", 32'(OUT_EMPTY), 32'd1);
    check("rst_data", OUT_DATA, 32'h0);
    check("rst_inread", 32'(IN_READ), 32'h0);
    check("rst_rderr", 32'(OUT_RD_ERR), 32'd0);
    check("rst_wcnt", WORD_CNT, 32'd0);
    OUT_READ = 1'b1;
    step();
    check("t3_rderr", 32'(OUT_RD_ERR), 32'd1);
    check("t3_empty", 32'(OUT_EMPTY), 32'd1);
    check("t3_wcnt", WORD_CNT, 32'd0);
    OUT_READ = 1'b0;
    step();
    check("t3_rderr_clr", 32'(OUT_RD_ERR), 32'd0);

    // Four always-full channels with continuous sink
    do_reset();
    src_fixed = 1'b1;
    for (int k = 0; k < N; k++) set_src(k, 1000, 32'hA + 32'(k));
    OUT_READ = 1'b1;
    drive_src();
    step();
    check("t1_lat_empty", 32'(OUT_EMPTY), 32'd0);
    check("t1_lat_data", OUT_DATA, 32'h0000000A);
    for (int i = 0; i < 8; i++) step();
    check("t1_nout", 32'(outs.size()), 32'd8);
    for (int i = 0; i < 8 && i < outs.size(); i++)
      check($sformatf("t1_out%0d", i), outs[i], (32'(i % 4) << 30) | (32'hA + 32'(i % 4)));
    check("t1_wcnt", WORD_CNT, 32'd9);
    src_fixed = 1'b0;

    // Single channel into a stalled sink, then push+pop at cnt==2
    do_reset();
    set_src(2, 3, 32'h100);
    drive_src();
    step();
    check("t2_rd0", 32'(rd_seen), 32'h4);
    step();
    check("t2_rd1", 32'(rd_seen), 32'h4);
    step();
    check("t2_rd2", 32'(rd_seen), 32'h0);
    check("t2_empty", 32'(OUT_EMPTY), 32'd0);
    check("t2_head", OUT_DATA, 32'h80000100);
    check("t2_wcnt", WORD_CNT, 32'd2);
    OUT_READ = 1'b1;
    step();
    check("t2_rd3", 32'(rd_seen), 32'h4);
    check("t2_head2", OUT_DATA, 32'h80000101);
    check("t2_wcnt3", WORD_CNT, 32'd3);
    set_src(1, 1, 32'h55);
    drive_src();
    step();
    check("t5_rd", 32'(rd_seen), 32'h2);
    check("t5_head", OUT_DATA, 32'h80000102);
    check("t5_wcnt", WORD_CNT, 32'd4);
    step();
    check("t5_head_ch1", OUT_DATA, 32'h40000055);
    check("t5_not_empty", 32'(OUT_EMPTY), 32'd0);
    step();
    check("t5_drained", 32'(OUT_EMPTY), 32'd1);
    OUT_READ = 1'b0;

    // Only ch0 and ch2 enabled
    do_reset();
    CH_ENABLE = 4'b0101;
    for (int k = 0; k < N; k++) set_src(k, 4, 32'h10 * 32'(k + 1));
    OUT_READ = 1'b1;
    drive_src();
    for (int i = 0; i < 10; i++) step();
    check("t4_ngrant", 32'(grants.size()), 32'd8);
    for (int i = 0; i < 8 && i < grants.size(); i++)
      check($sformatf("t4_grant%0d", i), 32'(grants[i]), (i % 2 == 1) ? 32'd2 : 32'd0);
    check("t4_disabled_rd", 32'(rd_or & 4'b1010), 32'h0);
    check("t4_out0", (outs.size() > 0) ? outs[0] : 32'hDEAD, 32'h00000010);
    check("t4_out1", (outs.size() > 1) ? outs[1] : 32'hDEAD, 32'h80000030);
    check("t4_out2", (outs.size() > 2) ? outs[2] : 32'hDEAD, 32'h00000011);
    OUT_READ = 1'b0;

    // Two channels of five words each: burst or strict rotation depending on build
    do_reset();
    set_src(0, 5, 32'h200);
    set_src(1, 5, 32'h300);
    OUT_READ = 1'b1;
    drive_src();
    for (int i = 0; i < 12; i++) step();
`ifdef TDC_MERGE_BURST_EN
    exp_g = '{0, 0, 0, 1, 1, 1, 0, 0, 1, 1};
`else
    exp_g = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`endif
    check("t6_ngrant", 32'(grants.size()), 32'd10);
    for (int i = 0; i < 10 && i < grants.size(); i++)
      check($sformatf("t6_grant%0d", i), 32'(grants[i]), 32'(exp_g[i]));
    check("t6_wcnt", WORD_CNT, 32'd10);
    check("t6_empty", 32'(OUT_EMPTY), 32'd1);
    OUT_READ = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
